dac_pll_ctrl: RTL



---
 rtl/dac_pll_pkg.sv | 18 +
 rtl/dac_pll_ctrl_sync_2ff.sv | 25 ++
 rtl/dac_pll_ctrl.sv | 147 ++++++++++++++
 3 files changed

// File: rtl/dac_pll_pkg.sv
// Shared state encoding and default timing for the DAC PLL reset/lock sequencer.
package dac_pll_pkg;

    typedef enum logic [2:0] {
        ST_RESET_HOLD = 3'd0,
        ST_WAIT_LOCK  = 3'd1,
        ST_STABLE     = 3'd2,
        ST_RUN        = 3'd3,
        ST_FAULT      = 3'd4
    } pll_state_e;

    // Defaults for a 50 MHz reference: 1 ms lock window, ~20 us stability.
    localparam int unsigned DEF_RST_CYCLES   = 16;
    localparam int unsigned DEF_LOCK_TIMEOUT = 50000;
    localparam int unsigned DEF_LOCK_STABLE  = 1024;
    localparam int unsigned DEF_MAX_RETRY    = 3;

endpackage

// File: rtl/dac_pll_ctrl_sync_2ff.sv
// Generic single-bit two-flop synchronizer with synchronous active-high reset.
module sync_2ff (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_d,
    output logic o_q
);

    logic r_meta;
    logic r_sync;

    // Two back-to-back flops to settle metastability of the asynchronous input.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_meta <= 1'b0;
            r_sync <= 1'b0;
        end else begin
            r_meta <= i_d;
            r_sync <= r_meta;
        end
    end

    assign o_q = r_sync;

endmodule

// File: rtl/dac_pll_ctrl.sv
// DAC PLL reset/lock sequencer: pulses the PLL reset, qualifies lock, retries
// on timeout and holds the DAC datapath in reset until the PLL clock is good.
module dac_pll_ctrl
    import dac_pll_pkg::*;
#(
    parameter int unsigned RST_CYCLES   = DEF_RST_CYCLES,
    parameter int unsigned LOCK_TIMEOUT = DEF_LOCK_TIMEOUT,
    parameter int unsigned LOCK_STABLE  = DEF_LOCK_STABLE,
    parameter int unsigned MAX_RETRY    = DEF_MAX_RETRY,
    parameter int unsigned TIMER_W      = 16,
    parameter int unsigned RETRY_W      = 2
) (
    input  logic               clkin1,
    input  logic               rst,
    input  logic               restart,
    input  logic               pll_lock,
    output logic               pll_rst,
    output logic               dac_rst,
    output logic               clk_ready,
    output logic               lock_lost,
    output logic               fault,
    output logic [RETRY_W-1:0] retry_cnt,
    output logic [2:0]         state_dbg
);

    localparam int unsigned STAB_W = $clog2(LOCK_STABLE + 1);

    localparam logic [TIMER_W-1:0] RST_LAST   = TIMER_W'(RST_CYCLES - 1);
    localparam logic [TIMER_W-1:0] LOCK_LAST  = TIMER_W'(LOCK_TIMEOUT - 1);
    localparam logic [STAB_W-1:0]  STAB_LAST  = STAB_W'(LOCK_STABLE - 1);
    localparam logic [RETRY_W-1:0] RETRY_MAX  = RETRY_W'(MAX_RETRY);
    localparam logic [TIMER_W-1:0] TIMER_ONE  = TIMER_W'(1);
    localparam logic [STAB_W-1:0]  STAB_ONE   = STAB_W'(1);
    localparam logic [RETRY_W-1:0] RETRY_ONE  = RETRY_W'(1);

    pll_state_e         r_state;
    logic [TIMER_W-1:0] r_timer;
    logic [STAB_W-1:0]  r_stab;
    logic [RETRY_W-1:0] r_retry;
    logic               r_lock_lost;

    logic               w_lock_s;
    logic               w_timeout;
    logic               w_retry_full;
    pll_state_e         w_to_state;
    logic [RETRY_W-1:0] w_to_retry;

    sync_2ff u_lock_sync (
        .i_clk (clkin1),
        .i_rst (rst),
        .i_d   (pll_lock),
        .o_q   (w_lock_s)
    );

    // Timeout outcome is shared by WAIT_LOCK and STABLE; retry_cnt saturates.
    assign w_timeout    = (r_timer == LOCK_LAST);
    assign w_retry_full = (r_retry == RETRY_MAX);
    assign w_to_state   = w_retry_full ? ST_FAULT : ST_RESET_HOLD;
    assign w_to_retry   = w_retry_full ? r_retry : (r_retry + RETRY_ONE);

    // Sequencer FSM with phase timer, stability counter and retry counter.
    always_ff @(posedge clkin1) begin
        if (rst) begin
            r_state     <= ST_RESET_HOLD;
            r_timer     <= '0;
            r_stab      <= '0;
            r_retry     <= '0;
            r_lock_lost <= 1'b0;
        end else if (restart) begin
            r_state     <= ST_RESET_HOLD;
            r_timer     <= '0;
            r_stab      <= '0;
            r_retry     <= '0;
            r_lock_lost <= 1'b0;
        end else begin
            r_lock_lost <= 1'b0;
            unique case (r_state)
                ST_RESET_HOLD: begin
                    if (r_timer == RST_LAST) begin
                        r_state <= ST_WAIT_LOCK;
                        r_timer <= '0;
                    end else begin
                        r_timer <= r_timer + TIMER_ONE;
                    end
                end
                ST_WAIT_LOCK: begin
                    if (w_lock_s) begin
                        r_state <= ST_STABLE;
                        r_stab  <= '0;
                        r_timer <= r_timer + TIMER_ONE;
                    end else if (w_timeout) begin
                        r_state <= w_to_state;
                        r_retry <= w_to_retry;
                        r_timer <= '0;
                    end else begin
                        r_timer <= r_timer + TIMER_ONE;
                    end
                end
                ST_STABLE: begin
                    // Qualify is tested before timeout so it wins a same-cycle tie.
                    if (w_lock_s && (r_stab == STAB_LAST)) begin
                        r_state <= ST_RUN;
                        r_retry <= '0;
                        r_timer <= '0;
                        r_stab  <= '0;
                    end else if (w_timeout) begin
                        r_state <= w_to_state;
                        r_retry <= w_to_retry;
                        r_timer <= '0;
                        r_stab  <= '0;
                    end else if (!w_lock_s) begin
                        r_state <= ST_WAIT_LOCK;
                        r_stab  <= '0;
                        r_timer <= r_timer + TIMER_ONE;
                    end else begin
                        r_stab  <= r_stab + STAB_ONE;
                        r_timer <= r_timer + TIMER_ONE;
                    end
                end
                ST_RUN: begin
                    if (!w_lock_s) begin
                        r_state     <= ST_RESET_HOLD;
                        r_timer     <= '0;
                        r_lock_lost <= 1'b1;
                    end
                end
                ST_FAULT: begin
                    r_state <= ST_FAULT;
                end
                default: begin
                    r_state <= ST_RESET_HOLD;
                    r_timer <= '0;
                    r_stab  <= '0;
                end
            endcase
        end
    end

    assign pll_rst   = (r_state == ST_RESET_HOLD) || (r_state == ST_FAULT);
    assign dac_rst   = (r_state != ST_RUN);
    assign clk_ready = (r_state == ST_RUN);
    assign fault     = (r_state == ST_FAULT);
    assign lock_lost = r_lock_lost;
    assign retry_cnt = r_retry;
    assign state_dbg = r_state;

endmodule
